// File: rtl/t03_player_action_fsm.sv
// Multi-player attack/block/cooldown action FSM with edge-detected active-low buttons.
// One independent channel per player; everything except the stun pulse advances only on tick.

module t03_player_chan #(
   parameter int CNT_W      = 26,
   parameter int ATK_LEN    = 6718863,
   parameter int ATK_ACTIVE = 5039147,
   parameter int BLK_MAX    = 3359432,
   parameter int CD_LEN     = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_atk_n,
   input  logic       btn_blk_n,
   input  logic       hit_in,
   output logic [1:0] state,
   output logic       attack_live,
   output logic       block_live,
   output logic       resting,
   output logic       stunned
);
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ATK  = 2'b01,
      S_BLK  = 2'b10,
      S_CD   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] ATK_LAST = CNT_W'(ATK_LEN - 1);
   localparam logic [CNT_W-1:0] ATK_ACT  = CNT_W'(ATK_ACTIVE);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_MAX - 1);
   localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(CD_LEN - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             atk_prev_q, blk_prev_q;
   logic             stun_q, stun_d;
   logic             atk_edge, blk_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         atk_prev_q <= 1'b1;
         blk_prev_q <= 1'b1;
         stun_q     <= 1'b0;
      end else begin
         if (tick) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            atk_prev_q <= btn_atk_n;
            blk_prev_q <= btn_blk_n;
         end
         stun_q <= stun_d;
      end
   end

   assign atk_edge    = atk_prev_q & ~btn_atk_n;
   assign blk_edge    = blk_prev_q & ~btn_blk_n;
   // Block is live from the registered button so the output never glitches with raw input.
   assign attack_live = (state_q == S_ATK) && (cnt_q < ATK_ACT);
   assign block_live  = (state_q == S_BLK) && !blk_prev_q;
   assign resting     = ~(attack_live | block_live);
   assign state       = state_q;
   assign stunned     = stun_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stun_d  = 1'b0;
      if (tick) begin
         if (hit_in && !block_live) begin
            state_d = S_CD;
            cnt_d   = '0;
            stun_d  = 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (atk_edge) begin
                     state_d = S_ATK;
                     cnt_d   = '0;
                  end else if (blk_edge) begin
                     state_d = S_BLK;
                     cnt_d   = '0;
                  end
               end
               S_ATK: begin
                  if (cnt_q == ATK_LAST) begin
                     state_d = S_CD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
               S_BLK: begin
                  if (btn_blk_n || cnt_q == BLK_LAST) begin
                     state_d = S_CD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
               S_CD: begin
                  if (cnt_q == CD_LAST) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end
endmodule

module t03_player_action_fsm #(
   parameter int NUM_PLAYERS = 2,
   parameter int CNT_W       = 26,
   parameter int ATK_LEN     = 6718863,
   parameter int ATK_ACTIVE  = 5039147,
   parameter int BLK_MAX     = 3359432,
   parameter int CD_LEN      = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [NUM_PLAYERS-1:0]   btn_atk_n,
   input  logic [NUM_PLAYERS-1:0]   btn_blk_n,
   input  logic [NUM_PLAYERS-1:0]   hit_in,
   output logic [2*NUM_PLAYERS-1:0] player_state,
   output logic [NUM_PLAYERS-1:0]   attack_live,
   output logic [NUM_PLAYERS-1:0]   block_live,
   output logic [NUM_PLAYERS-1:0]   resting,
   output logic [NUM_PLAYERS-1:0]   stunned
);
   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      t03_player_chan #(
         .CNT_W(CNT_W), .ATK_LEN(ATK_LEN), .ATK_ACTIVE(ATK_ACTIVE),
         .BLK_MAX(BLK_MAX), .CD_LEN(CD_LEN)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .btn_atk_n   (btn_atk_n[p]),
         .btn_blk_n   (btn_blk_n[p]),
         .hit_in      (hit_in[p]),
         .state       (player_state[2*p +: 2]),
         .attack_live (attack_live[p]),
         .block_live  (block_live[p]),
         .resting     (resting[p]),
         .stunned     (stunned[p])
      );
   end
endmodule

// File: tb/tb_t03_player_action_fsm.sv
// Scoreboard bench: each directed step queues its hand-computed expectation,
// a negedge monitor pops and compares against the DUT outputs.

module tb_t03_player_action_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [1:0] btn_atk_n = 2'b11;
   logic [1:0] btn_blk_n = 2'b11;
   logic [1:0] hit_in = 2'b00;
   logic [3:0] player_state;
   logic [1:0] attack_live, block_live, resting, stunned;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] al, bl, rs, sn;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   t03_player_action_fsm #(
      .NUM_PLAYERS(2), .CNT_W(8), .ATK_LEN(6), .ATK_ACTIVE(4), .BLK_MAX(5), .CD_LEN(3)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .btn_atk_n(btn_atk_n), .btn_blk_n(btn_blk_n), .hit_in(hit_in),
      .player_state(player_state), .attack_live(attack_live), .block_live(block_live),
      .resting(resting), .stunned(stunned)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [3:0] es, input logic [1:0] eal, input logic [1:0] ebl,
                       input logic [1:0] esn);
      exp_t e;
      e.st = es; e.al = eal; e.bl = ebl; e.rs = ~(eal | ebl); e.sn = esn;
      q.push_back(e);
   endtask

   // Apply inputs for one clock, then queue the outputs expected after that edge.
   task automatic step(input logic t, input logic [1:0] an, input logic [1:0] bn,
                       input logic [1:0] h, input logic [3:0] es, input logic [1:0] eal,
                       input logic [1:0] ebl, input logic [1:0] esn);
      tick = t; btn_atk_n = an; btn_blk_n = bn; hit_in = h;
      @(posedge clk); #1;
      push(es, eal, ebl, esn);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = '{player_state, attack_live, block_live, resting, stunned};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL vec%0d st/al/bl/rs/sn got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                     vectors, a.st, a.al, a.bl, a.rs, a.sn, e.st, e.al, e.bl, e.rs, e.sn);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      push(4'h0, 2'b00, 2'b00, 2'b00);
      rst = 1'b0;

      // P0 attack held 20 ticks: ATTACK 6 (live 4), COOLDOWN 3, then IDLE with no retrigger
      for (int i = 0; i < 20; i++)
         step(1, 2'b10, 2'b11, 2'b00, (i < 6) ? 4'h1 : (i < 9) ? 4'h3 : 4'h0,
              (i < 4) ? 2'b01 : 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);

      // P0 block released after 2 ticks
      for (int i = 0; i < 2; i++) step(1, 2'b11, 2'b10, 2'b00, 4'h2, 2'b00, 2'b01, 2'b00);
      for (int i = 0; i < 4; i++)
         step(1, 2'b11, 2'b11, 2'b00, (i < 3) ? 4'h3 : 4'h0, 2'b00, 2'b00, 2'b00);

      // P0 block held 10 ticks: capped at 5
      for (int i = 0; i < 10; i++)
         step(1, 2'b11, 2'b10, 2'b00, (i < 5) ? 4'h2 : (i < 8) ? 4'h3 : 4'h0,
              2'b00, (i < 5) ? 2'b01 : 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);

      // Both P0 buttons fall together -> ATTACK; P1 block concurrently
      for (int i = 0; i < 6; i++)
         step(1, 2'b10, 2'b00, 2'b00, (i < 5) ? 4'h9 : 4'hD,
              (i < 4) ? 2'b01 : 2'b00, (i < 5) ? 2'b10 : 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'hF, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'hF, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h3, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);

      // Hit on P1 at ATTACK cnt=1 -> COOLDOWN + one-cycle stun
      step(1, 2'b01, 2'b11, 2'b00, 4'h4, 2'b10, 2'b00, 2'b00);
      step(1, 2'b01, 2'b11, 2'b00, 4'h4, 2'b10, 2'b00, 2'b00);
      step(1, 2'b01, 2'b11, 2'b10, 4'hC, 2'b00, 2'b00, 2'b10);
      step(1, 2'b01, 2'b11, 2'b00, 4'hC, 2'b00, 2'b00, 2'b00);
      step(1, 2'b01, 2'b11, 2'b00, 4'hC, 2'b00, 2'b00, 2'b00);
      step(1, 2'b01, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);

      // Hit on P1 while blocking is ignored
      step(1, 2'b11, 2'b01, 2'b00, 4'h8, 2'b00, 2'b10, 2'b00);
      step(1, 2'b11, 2'b01, 2'b10, 4'h8, 2'b00, 2'b10, 2'b00);
      step(1, 2'b11, 2'b01, 2'b00, 4'h8, 2'b00, 2'b10, 2'b00);
      for (int i = 0; i < 4; i++)
         step(1, 2'b11, 2'b11, 2'b00, (i < 3) ? 4'hC : 4'h0, 2'b00, 2'b00, 2'b00);

      // Hit on idle P0 still stuns
      step(1, 2'b11, 2'b11, 2'b01, 4'h3, 2'b00, 2'b00, 2'b01);
      step(1, 2'b11, 2'b11, 2'b00, 4'h3, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h3, 2'b00, 2'b00, 2'b00);
      step(1, 2'b11, 2'b11, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00);

      // Tick gated 1-in-4; hit without tick does nothing
      step(1, 2'b10, 2'b11, 2'b00, 4'h1, 2'b01, 2'b00, 2'b00);
      step(0, 2'b10, 2'b11, 2'b01, 4'h1, 2'b01, 2'b00, 2'b00);
      step(0, 2'b10, 2'b11, 2'b00, 4'h1, 2'b01, 2'b00, 2'b00);
      step(0, 2'b10, 2'b11, 2'b00, 4'h1, 2'b01, 2'b00, 2'b00);
      step(1, 2'b10, 2'b11, 2'b00, 4'h1, 2'b01, 2'b00, 2'b00);
      step(0, 2'b10, 2'b11, 2'b00, 4'h1, 2'b01, 2'b00, 2'b00);

      // Asynchronous reset mid-ATTACK
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      push(4'h0, 2'b00, 2'b00, 2'b00);
      @(negedge clk); #1;
      rst = 1'b0;
      tick = 1'b1;
      btn_atk_n = 2'b11;

      repeat (2) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
